// File: rtl/mlp_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mlp_layer_sequencer_if
// Brief    : Result stream (valid/ready) carrying one INT8 neuron output.
// Revision : 1.0 - initial release
// ============================================================================
interface mlp_layer_sequencer_if #(
    parameter int IDX_W = 4
) ();
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic [IDX_W-1:0] res_idx;
    logic             res_last;

    modport master (
        output res_valid,
        output res_data,
        output res_idx,
        output res_last,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_idx,
        input  res_last,
        output res_ready
    );
endinterface
`default_nettype wire

// File: rtl/mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mlp_layer_sequencer
// Brief    : Sequences one dense layer of 8-input INT8 neurons through a single
//            MAC + activation datapath. Optional watchdog: MLP_SEQ_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mlp_layer_sequencer #(
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = $clog2(NUM_NEURONS),
    parameter int WDOG_CYC    = 31
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    start,
    input  wire [1:0]              act_type,
    input  wire [63:0]             x_vec,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   wt_rd_en,
    output logic [IDX_W-1:0]       wt_addr,
    input  wire [63:0]             wt_row,
    input  wire [7:0]              wt_bias,
    output logic [63:0]            dp_data,
    output logic [63:0]            dp_weight,
    output logic [7:0]             dp_bias,
    output logic                   dp_mac_clear,
    output logic                   dp_mac_enable,
    output logic                   dp_act_enable,
    output logic [1:0]             dp_act_type,
    input  wire                    dp_mac_valid,
    input  wire                    dp_result_valid,
    input  wire [7:0]              dp_result,
    mlp_layer_sequencer_if.master  res
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_LOAD     = 4'd2,
        S_CLEAR    = 4'd3,
        S_MAC      = 4'd4,
        S_WAIT_MAC = 4'd5,
        S_SETTLE   = 4'd6,
        S_ACT      = 4'd7,
        S_WAIT_ACT = 4'd8,
        S_EMIT     = 4'd9,
        S_DONE     = 4'd10
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_settle;
    logic             r_busy;
    logic             r_done;
    logic             r_wt_rd_en;
    logic [IDX_W-1:0] r_wt_addr;
    logic [63:0]      r_dp_data;
    logic [63:0]      r_dp_weight;
    logic [7:0]       r_dp_bias;
    logic [1:0]       r_dp_act_type;
    logic             r_mac_clear;
    logic             r_mac_enable;
    logic             r_act_enable;
    logic             r_res_valid;
    logic [7:0]       r_res_data;
    logic [IDX_W-1:0] r_res_idx;
    logic             r_res_last;

`ifdef MLP_SEQ_WDOG_EN
    localparam int                  c_WDOG_W    = $clog2(WDOG_CYC + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYC - 1);
    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_error;
`endif

    // Every output is a register updated on the transition into the state
    // that owns it, so pulses are exactly one cycle and glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_settle      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_wt_rd_en    <= 1'b0;
            r_wt_addr     <= '0;
            r_dp_data     <= '0;
            r_dp_weight   <= '0;
            r_dp_bias     <= '0;
            r_dp_act_type <= '0;
            r_mac_clear   <= 1'b0;
            r_mac_enable  <= 1'b0;
            r_act_enable  <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_idx     <= '0;
            r_res_last    <= 1'b0;
`ifdef MLP_SEQ_WDOG_EN
            r_wdog        <= '0;
            r_error       <= 1'b0;
`endif
        end else begin
            r_done       <= 1'b0;
            r_wt_rd_en   <= 1'b0;
            r_mac_clear  <= 1'b0;
            r_mac_enable <= 1'b0;
            r_act_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dp_data     <= x_vec;
                        r_dp_act_type <= act_type;
                        r_idx         <= '0;
                        r_wt_addr     <= '0;
                        r_wt_rd_en    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    r_dp_weight <= wt_row;
                    r_dp_bias   <= wt_bias;
                    r_mac_clear <= 1'b1;
                    r_state     <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_mac_enable <= 1'b1;
                    r_state      <= S_MAC;
                end
                S_MAC: begin
`ifdef MLP_SEQ_WDOG_EN
                    r_wdog  <= '0;
`endif
                    r_state <= S_WAIT_MAC;
                end
                S_WAIT_MAC: begin
                    if (dp_mac_valid) begin
                        r_settle <= 1'b0;
                        r_state  <= S_SETTLE;
                    end
`ifdef MLP_SEQ_WDOG_EN
                    else if (r_wdog == c_WDOG_LAST) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                S_SETTLE: begin
                    if (r_settle) begin
                        r_act_enable <= 1'b1;
                        r_state      <= S_ACT;
                    end else begin
                        r_settle <= 1'b1;
                    end
                end
                S_ACT: begin
`ifdef MLP_SEQ_WDOG_EN
                    r_wdog  <= '0;
`endif
                    r_state <= S_WAIT_ACT;
                end
                S_WAIT_ACT: begin
                    if (dp_result_valid) begin
                        r_res_data  <= dp_result;
                        r_res_idx   <= r_idx;
                        r_res_last  <= (r_idx == c_LAST_IDX);
                        r_res_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end
`ifdef MLP_SEQ_WDOG_EN
                    else if (r_wdog == c_WDOG_LAST) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                S_EMIT: begin
                    if (res.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_res_last  <= 1'b0;
                        // Terminal compare comes before the increment so idx never wraps.
                        if (r_idx == c_LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_wt_addr  <= r_idx + 1'b1;
                            r_wt_rd_en <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MLP_SEQ_WDOG_EN
    assign error = r_error;
`else
    // Watchdog absent: error is a constant 0.
    localparam logic c_NO_WDOG_ERR = 1'b0 && (WDOG_CYC > 0);
    assign error = c_NO_WDOG_ERR;
`endif

    assign busy          = r_busy;
    assign done          = r_done;
    assign wt_rd_en      = r_wt_rd_en;
    assign wt_addr       = r_wt_addr;
    assign dp_data       = r_dp_data;
    assign dp_weight     = r_dp_weight;
    assign dp_bias       = r_dp_bias;
    assign dp_act_type   = r_dp_act_type;
    assign dp_mac_clear  = r_mac_clear;
    assign dp_mac_enable = r_mac_enable;
    assign dp_act_enable = r_act_enable;
    assign res.res_valid = r_res_valid;
    assign res.res_data  = r_res_data;
    assign res.res_idx   = r_res_idx;
    assign res.res_last  = r_res_last;

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_layer_sequencer
// Brief    : Self-checking bench: weight memory and datapath behavioural models,
//            directed and randomized layers checked against INT8 neuron maths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_layer_sequencer;

    localparam int c_N     = 4;
    localparam int c_IDX_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [1:0]         act_type;
    logic [63:0]        x_vec;
    logic               busy, done, error;
    logic               wt_rd_en;
    logic [c_IDX_W-1:0] wt_addr;
    logic [63:0]        wt_row;
    logic [7:0]         wt_bias;
    logic [63:0]        dp_data, dp_weight;
    logic [7:0]         dp_bias;
    logic               dp_mac_clear, dp_mac_enable, dp_act_enable;
    logic [1:0]         dp_act_type;
    logic               dp_mac_valid, dp_result_valid;
    logic [7:0]         dp_result;

    mlp_layer_sequencer_if #(.IDX_W(c_IDX_W)) res_if ();

    mlp_layer_sequencer #(
        .NUM_NEURONS(c_N), .IDX_W(c_IDX_W), .WDOG_CYC(31)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .act_type(act_type), .x_vec(x_vec),
        .busy(busy), .done(done), .error(error),
        .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_row(wt_row), .wt_bias(wt_bias),
        .dp_data(dp_data), .dp_weight(dp_weight), .dp_bias(dp_bias),
        .dp_mac_clear(dp_mac_clear), .dp_mac_enable(dp_mac_enable),
        .dp_act_enable(dp_act_enable), .dp_act_type(dp_act_type),
        .dp_mac_valid(dp_mac_valid), .dp_result_valid(dp_result_valid),
        .dp_result(dp_result), .res(res_if.master)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] mem_w [c_N];
    logic [7:0]  mem_b [c_N];
    int          dly_lo = 0, dly_hi = 0;
    bit          hold_mac_low = 1'b0;
    bit          spur_en = 1'b0;
    logic [7:0]  spur_val = 8'h00;

    // Signed dot product plus bias, then ReLU (00) or pass-through (11),
    // saturated to INT8.
    function automatic logic [7:0] ref_neuron(input logic [1:0] act, input logic [63:0] x,
                                              input logic [63:0] w, input logic [7:0] b);
        logic signed [7:0] xs, ws, bs;
        int acc;
        bs  = b;
        acc = int'(bs);
        for (int i = 0; i < 8; i++) begin
            xs  = x[8*i +: 8];
            ws  = w[8*i +: 8];
            acc = acc + int'(xs) * int'(ws);
        end
        if (act == 2'b00 && acc < 0) acc = 0;
        if (acc > 127)  acc = 127;
        if (acc < -128) acc = -128;
        return acc[7:0];
    endfunction

    function automatic logic [63:0] rep8(input logic [7:0] v);
        return {8{v}};
    endfunction

    // Weight memory: data valid the cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (wt_rd_en) begin
            wt_row  <= mem_w[wt_addr];
            wt_bias <= mem_b[wt_addr];
        end else begin
            wt_row  <= {$urandom, $urandom};
            wt_bias <= 8'($urandom);
        end
    end

    // Datapath model: valid pulses after a random latency in [dly_lo, dly_hi].
    bit         mac_arm = 1'b0, act_arm = 1'b0;
    int         mac_cnt = 0, act_cnt = 0;
    logic [7:0] act_res = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            mac_arm <= 1'b0;
            act_arm <= 1'b0;
        end else begin
            if (dp_mac_enable && !hold_mac_low) begin
                mac_arm <= 1'b1;
                mac_cnt <= $urandom_range(dly_hi, dly_lo);
            end else if (mac_arm) begin
                if (mac_cnt == 0) mac_arm <= 1'b0;
                else              mac_cnt <= mac_cnt - 1;
            end
            if (dp_act_enable) begin
                act_arm <= 1'b1;
                act_cnt <= $urandom_range(dly_hi, dly_lo);
                act_res <= ref_neuron(dp_act_type, dp_data, dp_weight, dp_bias);
            end else if (act_arm) begin
                if (act_cnt == 0) act_arm <= 1'b0;
                else              act_cnt <= act_cnt - 1;
            end
        end
    end

    assign dp_mac_valid    = (mac_arm && mac_cnt == 0) || spur_en;
    assign dp_result_valid = (act_arm && act_cnt == 0) || spur_en;
    assign dp_result       = spur_en ? spur_val : act_res;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_layer(input logic [1:0] act, input logic [63:0] x, input int lo,
                             input int hi, input int stall_at, input int stall_len,
                             input bit rand_stall, input bit chk_lat);
        int cyc;
        int nst;
        logic [7:0] exp;
        dly_lo = lo;
        dly_hi = hi;
        @(negedge clk);
        x_vec = x; act_type = act; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x_vec = {$urandom, $urandom}; act_type = 2'($urandom);
        check("fetch0_rd_en", wt_rd_en, 1);
        check("fetch0_addr", wt_addr, 0);
        check("busy_in_fetch", busy, 1);
        for (int n = 0; n < c_N; n++) begin
            cyc = 0;
            if (chk_lat && n == 0) begin
                @(negedge clk); check("load_rd_en_low", wt_rd_en, 0);
                @(negedge clk); check("clear_pulse", dp_mac_clear, 1);
                @(negedge clk); check("mac_pulse", dp_mac_enable, 1);
                check("clear_one_cycle", dp_mac_clear, 0);
                cyc = 3;
            end
            while (!res_if.res_valid && cyc < 300) begin
                @(negedge clk);
                cyc++;
            end
            check("emit_reached", res_if.res_valid, 1);
            if (!res_if.res_valid) return;
            if (chk_lat) check("neuron_latency", cyc, 9);
            exp = ref_neuron(act, x, mem_w[n], mem_b[n]);
            check("res_data", res_if.res_data, exp);
            check("res_idx", res_if.res_idx, n);
            check("res_last", res_if.res_last, (n == c_N - 1));
            check("dp_weight", dp_weight, mem_w[n]);
            check("dp_bias", dp_bias, mem_b[n]);
            check("dp_data", dp_data, x);
            check("dp_act_type", dp_act_type, act);
            nst = (n == stall_at) ? stall_len : (rand_stall ? $urandom_range(3, 0) : 0);
            for (int s = 0; s < nst; s++) begin
                res_if.res_ready = 1'b0;
                spur_en  = 1'b1;
                spur_val = 8'($urandom);
                @(negedge clk);
                check("stall_valid", res_if.res_valid, 1);
                check("stall_data", res_if.res_data, exp);
                check("stall_idx", res_if.res_idx, n);
                check("stall_no_fetch", wt_rd_en, 0);
            end
            spur_en = 1'b0;
            res_if.res_ready = 1'b1;
            @(negedge clk);
            check("valid_drop_after_accept", res_if.res_valid, 0);
            if (n < c_N - 1) begin
                check("next_fetch_rd_en", wt_rd_en, 1);
                check("next_fetch_addr", wt_addr, n + 1);
                check("no_early_done", done, 0);
            end else begin
                check("done_pulse", done, 1);
                check("busy_in_done", busy, 1);
                @(negedge clk);
                check("done_one_cycle", done, 0);
                check("idle_busy_low", busy, 0);
            end
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; act_type = 2'b00; x_vec = '0;
        res_if.res_ready = 1'b1;
        for (int i = 0; i < c_N; i++) begin
            mem_w[i] = rep8(8'd1);
            mem_b[i] = 8'd0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_res_valid", res_if.res_valid, 0);
        check("rst_res_last", res_if.res_last, 0);
        check("rst_res_data", res_if.res_data, 0);
        check("rst_res_idx", res_if.res_idx, 0);
        check("rst_pulses", {wt_rd_en, dp_mac_clear, dp_mac_enable, dp_act_enable}, 0);
        check("rst_wt_addr", wt_addr, 0);
        check("rst_dp_regs", {dp_data ^ dp_weight, dp_bias, dp_act_type}, 0);
        check("rst_dp_data", dp_data, 0);

        // Unit rows, unit inputs: every neuron yields 8; zero-wait latency.
        run_layer(2'b00, rep8(8'd1), 0, 0, -1, 0, 1'b0, 1'b1);

        // 53, ReLU clamp to 0, plus a 10-cycle stall on idx 1.
        mem_w[0] = rep8(8'd3);   mem_b[0] = 8'd5;
        mem_w[1] = rep8(8'hFF);  mem_b[1] = 8'd0;
        mem_w[2] = {$urandom, $urandom}; mem_b[2] = 8'($urandom);
        mem_w[3] = {$urandom, $urandom}; mem_b[3] = 8'($urandom);
        run_layer(2'b00, rep8(8'd2), 0, 0, 1, 10, 1'b0, 1'b0);

        // Positive saturation.
        mem_w[0] = rep8(8'd10);  mem_b[0] = 8'd0;
        run_layer(2'b00, rep8(8'd20), 0, 3, -1, 0, 1'b0, 1'b0);

        // Pass-through: 3*2*8 + 4 = 52; negative sums kept.
        mem_w[0] = rep8(8'd2);   mem_b[0] = 8'd4;
        mem_w[1] = rep8(8'hFE);  mem_b[1] = 8'd1;
        run_layer(2'b11, rep8(8'd3), 1, 3, -1, 0, 1'b0, 1'b0);

        // Randomized layers.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < c_N; i++) begin
                mem_w[i] = {$urandom, $urandom};
                mem_b[i] = 8'($urandom);
            end
            run_layer(($urandom_range(1, 0) == 1) ? 2'b11 : 2'b00, {$urandom, $urandom},
                      0, 4, -1, 0, 1'b1, 1'b0);
        end

        // Reset while waiting for the activation result.
        dly_lo = 20; dly_hi = 20;
        @(negedge clk); x_vec = rep8(8'd1); act_type = 2'b00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!dp_act_enable && cyc < 100) begin @(negedge clk); cyc++; end
        check("reach_act", dp_act_enable, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_res_valid", res_if.res_valid, 0);
        check("midrst_done", done, 0);
        repeat (25) @(negedge clk);
        check("midrst_stays_idle", {busy, res_if.res_valid, wt_rd_en}, 0);
        for (int i = 0; i < c_N; i++) begin
            mem_w[i] = {$urandom, $urandom};
            mem_b[i] = 8'($urandom);
        end
        run_layer(2'b00, {$urandom, $urandom}, 0, 2, -1, 0, 1'b0, 1'b0);

        // Datapath that never answers.
        hold_mac_low = 1'b1;
        dly_lo = 0; dly_hi = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!dp_mac_enable && cyc < 20) begin @(negedge clk); cyc++; end
        check("hang_mac_pulse", dp_mac_enable, 1);
`ifdef MLP_SEQ_WDOG_EN
        for (int k = 0; k < 31; k++) @(negedge clk);
        check("wdog_not_early", error, 0);
        @(negedge clk);
        check("wdog_error_set", error, 1);
        check("wdog_done_pulse", done, 1);
        @(negedge clk);
        check("wdog_busy_low", busy, 0);
        check("wdog_done_one_cycle", done, 0);
        repeat (10) @(negedge clk);
        check("wdog_error_sticky", error, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wdog_error_cleared", error, 0);
`else
        repeat (50) @(negedge clk);
        check("hang_busy_held", busy, 1);
        check("hang_no_error", error, 0);
        check("hang_no_done", done, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("hang_rst_idle", busy, 0);
`endif
        hold_mac_low = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mlp_layer_sequencer.md
# mlp_layer_sequencer

- Control initiator for `mlp_compute_datapath`: sequences one dense layer of `NUM_NEURONS` 8-input INT8 neurons through the single MAC + activation datapath.
- Per neuron it fetches weights and bias from weight memory, drives the clear → MAC → activation pulse protocol, captures the INT8 result, and streams it out on a valid/ready port.
- Sits between the layer controller (start/done) and the datapath instance.

## Interface
- `NUM_NEURONS`, 16: neurons per layer; ≥2.
- `IDX_W`, `$clog2(NUM_NEURONS)`: neuron index width.
- `WDOG_CYC`, 31: watchdog limit in cycles; only used with `MLP_SEQ_WDOG_EN`.
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `start` in 1: begin layer; sampled only in IDLE.
- `act_type` in 2: activation select; latched at start; 00 = ReLU, 11 = pass-through.
- `x_vec` in 64: eight signed INT8 inputs, lane i = bits [8i+7:8i]; latched at start.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last result is accepted.
- `error` out 1: sticky watchdog flag.
- `wt_rd_en` out 1: weight memory read strobe.
- `wt_addr` out IDX_W: neuron index being read.
- `wt_row` in 64: eight signed INT8 weights; valid the cycle after `wt_rd_en`.
- `wt_bias` in 8: signed INT8 bias; valid the cycle after `wt_rd_en`.
- `dp_data` out 64: latched `x_vec`.
- `dp_weight` out 64: latched `wt_row`.
- `dp_bias` out 8: latched `wt_bias`.
- `dp_mac_clear` out 1: one-cycle pulse.
- `dp_mac_enable` out 1: one-cycle pulse.
- `dp_act_enable` out 1: one-cycle pulse.
- `dp_act_type` out 2: latched `act_type`.
- `dp_mac_valid` in 1: from datapath.
- `dp_result_valid` in 1: from datapath.
- `dp_result` in 8: from datapath.
- `res_valid` out 1: result stream valid.
- `res_ready` in 1: result stream ready.
- `res_data` out 8: signed INT8 result.
- `res_idx` out IDX_W: neuron index of `res_data`.
- `res_last` out 1: high with the result of index `NUM_NEURONS-1`.

## Operation
- FSM: IDLE → FETCH → LOAD → CLEAR → MAC → WAIT_MAC → SETTLE → ACT → WAIT_ACT → EMIT → (FETCH | DONE) → IDLE.
- IDLE: if `start`, latch `x_vec` and `act_type`, set idx = 0, go to FETCH.
- FETCH: `wt_rd_en` = 1, `wt_addr` = idx.
- LOAD: latch `wt_row` and `wt_bias` into the `dp_*` registers.
- CLEAR: `dp_mac_clear` = 1.
- MAC: `dp_mac_enable` = 1.
- WAIT_MAC: hold until `dp_mac_valid` = 1.
- SETTLE: exactly 2 cycles, for the accumulator update.
- ACT: `dp_act_enable` = 1.
- WAIT_ACT: hold until `dp_result_valid`; latch `dp_result` into `res_data` in that same cycle.
- EMIT: `res_valid` = 1 with stable `res_data`/`res_idx`/`res_last` until `res_valid && res_ready`.
  - On acceptance: if idx = `NUM_NEURONS-1`, go to DONE; else idx += 1 and go to FETCH.
- DONE: `done` = 1 for one cycle, then IDLE.
- All outputs are registered or decoded from registered state. Pulses are exactly one cycle wide.
- `start` outside IDLE is ignored. `act_type`/`x_vec` changes after the start cycle have no effect.
- Index arithmetic is unsigned IDX_W. idx never wraps: the terminal compare precedes the increment.
- `dp_mac_valid`/`dp_result_valid` seen outside their wait states are ignored.

## Timing
- Reset values:
  - state = IDLE, idx = 0.
  - All pulse outputs, `busy`, `done`, `res_valid`, `res_last`, `error` = 0.
  - `wt_addr`, `res_idx`, `res_data`, `dp_*` data/bias/type = 0.
- `rst` in any state returns to IDLE on the next edge and drops any pending result. It takes priority over `start` and over handshakes.
- Start accepted at edge T:
  - T+1: FETCH.
  - T+2: LOAD.
  - T+3: CLEAR.
  - T+4: MAC.
  - T+5 onward: WAIT_MAC.
- Minimum per-neuron latency (FETCH to first EMIT cycle), with zero-wait valids: 9 cycles.
- Back-to-back: FETCH of neuron n+1 is the cycle after acceptance of neuron n.
- `res_ready` held low stalls indefinitely in EMIT, with outputs stable.

## Configuration
- `MLP_SEQ_WDOG_EN` defined:
  - A counter runs in WAIT_MAC and in WAIT_ACT and resets on state entry.
  - Reaching `WDOG_CYC` sets `error`, which stays set until `rst`.
  - The FSM then goes to DONE (pulse `done`) and on to IDLE.
- Not defined: the wait states hold indefinitely, `error` is tied 0, and no counter logic exists.

## Test plan
- NUM_NEURONS=4, x = all 1, rows {all 1, b 0}, ReLU, paired with the real datapath:
  - Stream = 8 with idx 0.
  - `done` one cycle after the idx-3 acceptance.
  - `res_last` high only on idx 3.
- x = all 2, weights = all 3, bias 5, ReLU → 53. Weights all −1 with x = all 2 → 0 (ReLU clamp).
- x = all 20, weights all 10 → 127 (saturation). x = all 3, weights all 2, bias 4, `act_type` = 11 → 52.
- `res_ready` low for 10 cycles on idx 1 → `res_valid`/`res_data` stable throughout. `wt_rd_en` for idx 2 occurs only the cycle after acceptance.
- `rst` asserted in WAIT_ACT → next cycle: IDLE, `busy` = 0, no `res_valid`. A new `start` then restarts at idx 0.
- With `MLP_SEQ_WDOG_EN`, `WDOG_CYC` = 31, `dp_mac_valid` held low → `error` = 1 after 31 wait cycles, then a `done` pulse, then `busy` = 0. `error` remains set until `rst`.
